pipe_ctrl_regs: RTL

- Control-side pipeline register bank for the 5-stage MIPS core: ID/EX, EX/MEM and MEM/WB control and destination registers.
- Consumes the decoded control word and register fields from ID, and the IDExFlush bubble request.
- Produces the stage-tagged signals the hazard and forwarding logic consume: IDExMemRead, IDExRs/Rt, ExMemRd, ExMemRegWrite, MemWBRd, MemWBRegWrite.
- Resolves the write-back destination register in EX and keeps retire/bubble statistics.

---
 rtl/pipe_ctrl_regs.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl_regs.sv
// pipe_ctrl_regs
//   Control-side pipeline register bank of the 5-stage MIPS core. Holds the
//   ID/EX, EX/MEM and MEM/WB control words and register fields, resolves the
//   write-back destination in EX and counts retired instructions and inserted
//   bubbles.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   idValid, id*        decoded control word and register fields from ID
//   IDExFlush           bubble request from the hazard unit
//   IDEx*               ID/EX stage control and register fields
//   ExMem*              EX/MEM stage control and resolved destination
//   MemWB*              MEM/WB stage control and resolved destination
//   retireCount         valid instructions leaving MEM/WB (saturating)
//   bubbleCount         bubbles inserted by IDExFlush (saturating)
//
// Every stage advances every cycle; there are no stage enables. All outputs
// come straight from flops, so there is no input-to-output combinational path.
module pipe_ctrl_regs #(
    parameter int COUNT_W     = 16,
    parameter bit SUPPRESS_R0 = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               idValid,
    input  logic               IDExFlush,
    input  logic               idALUSrc,
    input  logic [1:0]         idRegDst,
    input  logic               idMemRead,
    input  logic               idMemWrite,
    input  logic [1:0]         idRegData,
    input  logic               idRegWrite,
    input  logic [2:0]         idALUOpc,
    input  logic [4:0]         idRs,
    input  logic [4:0]         idRt,
    input  logic [4:0]         idRd,
    output logic               IDExValid,
    output logic               IDExALUSrc,
    output logic               IDExMemRead,
    output logic               IDExMemWrite,
    output logic               IDExRegWrite,
    output logic [1:0]         IDExRegDst,
    output logic [1:0]         IDExRegData,
    output logic [2:0]         IDExALUOpc,
    output logic [4:0]         IDExRs,
    output logic [4:0]         IDExRt,
    output logic [4:0]         IDExRd,
    output logic               ExMemValid,
    output logic               ExMemMemRead,
    output logic               ExMemMemWrite,
    output logic               ExMemRegWrite,
    output logic [1:0]         ExMemRegData,
    output logic [4:0]         ExMemRd,
    output logic               MemWBValid,
    output logic               MemWBRegWrite,
    output logic [1:0]         MemWBRegData,
    output logic [4:0]         MemWBRd,
    output logic [COUNT_W-1:0] retireCount,
    output logic [COUNT_W-1:0] bubbleCount
);

    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

    // ID/EX
    logic       idex_valid_q, idex_valid_d;
    logic       idex_alu_src_q, idex_alu_src_d;
    logic       idex_mem_read_q, idex_mem_read_d;
    logic       idex_mem_write_q, idex_mem_write_d;
    logic       idex_reg_write_q, idex_reg_write_d;
    logic [1:0] idex_reg_dst_q, idex_reg_dst_d;
    logic [1:0] idex_reg_data_q, idex_reg_data_d;
    logic [2:0] idex_alu_opc_q, idex_alu_opc_d;
    logic [4:0] idex_rs_q, idex_rs_d;
    logic [4:0] idex_rt_q, idex_rt_d;
    logic [4:0] idex_rd_q, idex_rd_d;
    // EX/MEM
    logic       exmem_valid_q, exmem_valid_d;
    logic       exmem_mem_read_q, exmem_mem_read_d;
    logic       exmem_mem_write_q, exmem_mem_write_d;
    logic       exmem_reg_write_q, exmem_reg_write_d;
    logic [1:0] exmem_reg_data_q, exmem_reg_data_d;
    logic [4:0] exmem_rd_q, exmem_rd_d;
    // MEM/WB
    logic       memwb_valid_q, memwb_valid_d;
    logic       memwb_reg_write_q, memwb_reg_write_d;
    logic [1:0] memwb_reg_data_q, memwb_reg_data_d;
    logic [4:0] memwb_rd_q, memwb_rd_d;
    // statistics
    logic [COUNT_W-1:0] retire_cnt_q, retire_cnt_d;
    logic [COUNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    logic [4:0] resolved_rd;

    always_comb begin
        // A flush turns the ID/EX slot into an all-zero bubble, so the hazard
        // and forwarding logic never see stale MemRead/RegWrite from it.
        if (IDExFlush) begin
            idex_valid_d     = 1'b0;
            idex_alu_src_d   = 1'b0;
            idex_mem_read_d  = 1'b0;
            idex_mem_write_d = 1'b0;
            idex_reg_write_d = 1'b0;
            idex_reg_dst_d   = 2'b00;
            idex_reg_data_d  = 2'b00;
            idex_alu_opc_d   = 3'b000;
            idex_rs_d        = 5'd0;
            idex_rt_d        = 5'd0;
            idex_rd_d        = 5'd0;
        end else begin
            idex_valid_d     = idValid;
            idex_alu_src_d   = idALUSrc;
            idex_mem_read_d  = idMemRead;
            idex_mem_write_d = idMemWrite;
            idex_reg_write_d = idRegWrite;
            idex_reg_dst_d   = idRegDst;
            idex_reg_data_d  = idRegData;
            idex_alu_opc_d   = idALUOpc;
            idex_rs_d        = idRs;
            idex_rt_d        = idRt;
            idex_rd_d        = idRd;
        end

        // Destination: rt for I-type, rd for R-type, r31 for jal.
        case (idex_reg_dst_q)
            2'b01:   resolved_rd = idex_rd_q;
            2'b10:   resolved_rd = 5'd31;
            default: resolved_rd = idex_rt_q;
        endcase

        exmem_valid_d     = idex_valid_q;
        exmem_mem_read_d  = idex_mem_read_q;
        exmem_mem_write_d = idex_mem_write_q;
        exmem_reg_data_d  = idex_reg_data_q;
        exmem_rd_d        = resolved_rd;
        // Writes to r0 are dropped here so forwarding never matches on r0.
        if (SUPPRESS_R0 && (resolved_rd == 5'd0)) begin
            exmem_reg_write_d = 1'b0;
        end else begin
            exmem_reg_write_d = idex_reg_write_q;
        end

        memwb_valid_d     = exmem_valid_q;
        memwb_reg_write_d = exmem_reg_write_q;
        memwb_reg_data_d  = exmem_reg_data_q;
        memwb_rd_d        = exmem_rd_q;

        retire_cnt_d = retire_cnt_q;
        if (memwb_valid_q && (retire_cnt_q != CNT_MAX)) begin
            retire_cnt_d = retire_cnt_q + 1'b1;
        end
        bubble_cnt_d = bubble_cnt_q;
        if (IDExFlush && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_valid_q      <= 1'b0;
            idex_alu_src_q    <= 1'b0;
            idex_mem_read_q   <= 1'b0;
            idex_mem_write_q  <= 1'b0;
            idex_reg_write_q  <= 1'b0;
            idex_reg_dst_q    <= 2'b00;
            idex_reg_data_q   <= 2'b00;
            idex_alu_opc_q    <= 3'b000;
            idex_rs_q         <= 5'd0;
            idex_rt_q         <= 5'd0;
            idex_rd_q         <= 5'd0;
            exmem_valid_q     <= 1'b0;
            exmem_mem_read_q  <= 1'b0;
            exmem_mem_write_q <= 1'b0;
            exmem_reg_write_q <= 1'b0;
            exmem_reg_data_q  <= 2'b00;
            exmem_rd_q        <= 5'd0;
            memwb_valid_q     <= 1'b0;
            memwb_reg_write_q <= 1'b0;
            memwb_reg_data_q  <= 2'b00;
            memwb_rd_q        <= 5'd0;
            retire_cnt_q      <= '0;
            bubble_cnt_q      <= '0;
        end else begin
            idex_valid_q      <= idex_valid_d;
            idex_alu_src_q    <= idex_alu_src_d;
            idex_mem_read_q   <= idex_mem_read_d;
            idex_mem_write_q  <= idex_mem_write_d;
            idex_reg_write_q  <= idex_reg_write_d;
            idex_reg_dst_q    <= idex_reg_dst_d;
            idex_reg_data_q   <= idex_reg_data_d;
            idex_alu_opc_q    <= idex_alu_opc_d;
            idex_rs_q         <= idex_rs_d;
            idex_rt_q         <= idex_rt_d;
            idex_rd_q         <= idex_rd_d;
            exmem_valid_q     <= exmem_valid_d;
            exmem_mem_read_q  <= exmem_mem_read_d;
            exmem_mem_write_q <= exmem_mem_write_d;
            exmem_reg_write_q <= exmem_reg_write_d;
            exmem_reg_data_q  <= exmem_reg_data_d;
            exmem_rd_q        <= exmem_rd_d;
            memwb_valid_q     <= memwb_valid_d;
            memwb_reg_write_q <= memwb_reg_write_d;
            memwb_reg_data_q  <= memwb_reg_data_d;
            memwb_rd_q        <= memwb_rd_d;
            retire_cnt_q      <= retire_cnt_d;
            bubble_cnt_q      <= bubble_cnt_d;
        end
    end

    assign IDExValid     = idex_valid_q;
    assign IDExALUSrc    = idex_alu_src_q;
    assign IDExMemRead   = idex_mem_read_q;
    assign IDExMemWrite  = idex_mem_write_q;
    assign IDExRegWrite  = idex_reg_write_q;
    assign IDExRegDst    = idex_reg_dst_q;
    assign IDExRegData   = idex_reg_data_q;
    assign IDExALUOpc    = idex_alu_opc_q;
    assign IDExRs        = idex_rs_q;
    assign IDExRt        = idex_rt_q;
    assign IDExRd        = idex_rd_q;
    assign ExMemValid    = exmem_valid_q;
    assign ExMemMemRead  = exmem_mem_read_q;
    assign ExMemMemWrite = exmem_mem_write_q;
    assign ExMemRegWrite = exmem_reg_write_q;
    assign ExMemRegData  = exmem_reg_data_q;
    assign ExMemRd       = exmem_rd_q;
    assign MemWBValid    = memwb_valid_q;
    assign MemWBRegWrite = memwb_reg_write_q;
    assign MemWBRegData  = memwb_reg_data_q;
    assign MemWBRd       = memwb_rd_q;
    assign retireCount   = retire_cnt_q;
    assign bubbleCount   = bubble_cnt_q;

endmodule
